mem_responder: RTL
==================

Name: mem_responder

Overview:
- Memory-side counterpart of the request unit: consumes imemREN / dmemREN / dmemWEN and returns ihit / dhit with load data.
- Arbitrates instruction and data requests onto one single-ported RAM with a fixed wait-state latency.
- Sits between the datapath request interface and the RAM model.

Parameters:
LAT, 2, RAM wait states per access (legal range 1..15).

Ports:
CLK  in  1  clock, rising edge
nRST  in  1  synchronous active-low reset
imemREN  in  1  instruction read request
imemaddr  in  32  instruction address (word_t)
dmemREN  in  1  data read request
dmemWEN  in  1  data write request
dmemaddr  in  32  data address
dmemstore  in  32  data write value
ihit  out  1  instruction access complete, one-cycle pulse
dhit  out  1  data access complete, one-cycle pulse
imemload  out  32  fetched instruction, held until next ihit
dmemload  out  32  loaded data, held until next data read dhit
ramREN  out  1  RAM read enable
ramWEN  out  1  RAM write enable
ramaddr  out  32  RAM address
ramstore  out  32  RAM write data
ramload  in  32  RAM read data, valid in the last ACCESS cycle

Behaviour:
- Reset (nRST low at a CLK edge): state IDLE, wait counter 0, grant NONE.
  - Outputs after reset: ihit=0, dhit=0, imemload=0, dmemload=0, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
  - Reset during ACCESS aborts the access; no hit is issued.
- FSM states: IDLE, ACCESS, DONE. All outputs are registered or decoded from registered state only; there is no combinational input-to-output path.
- IDLE:
  - If dmemWEN or dmemREN is high: grant DATA.
    - Latch dmemaddr and dmemstore.
    - Latch op = WRITE if dmemWEN is high, else READ. WEN wins when both are high.
  - Else if imemREN is high: grant INSTR, latch imemaddr, op = READ.
  - Else stay in IDLE.
  - On any grant: counter = LAT-1, go to ACCESS.
  - Data always has priority over instruction.
- ACCESS:
  - ramaddr and ramstore are driven from the latched values.
  - ramREN = (op == READ); ramWEN = (op == WRITE).
  - Counter decrements each cycle. When counter == 0, the edge captures ramload into imemload (INSTR) or dmemload (DATA READ); go to DONE.
  - A write does not modify dmemload.
  - Abort: if the granted request input drops during ACCESS (INSTR: imemREN == 0; DATA: dmemREN == 0 and dmemWEN == 0), return to IDLE. No hit, load registers unchanged, RAM enables low the next cycle.
- DONE:
  - Exactly one cycle. ihit=1 if grant was INSTR, dhit=1 if grant was DATA; never both.
  - RAM enables are 0. Next state is IDLE unconditionally. This turnaround cycle lets the request unit drop its enable before the next arbitration.
- Latency:
  - Request high in cycle 0 from IDLE gives ACCESS in cycles 1..LAT and hit in cycle LAT+1.
  - Back-to-back throughput: one access per LAT+2 cycles.
- Simultaneous imem and dmem requests: data is serviced first, instruction next.
  - Instruction starvation is impossible: the request unit clears its data enables after dhit.
- Request inputs changing while in DONE are ignored. Address or data changes during ACCESS are ignored because the latched copies are used.
- Counter width is 4 bits, fixed by the LAT ≤ 15 limit. LAT = 1 gives one ACCESS cycle.

Decomposition:
- cpu_types_pkg additions:
  - word_t (existing).
  - memstate_t enum {IDLE, ACCESS, DONE}.
  - memgrant_t enum {NONE, INSTR, DATA}.
  - memop_t enum {READ, WRITE}.
- Optional single sub-module mem_wait_counter: loadable down-counter with a zero flag, instantiated once.

Test Plan:
- Instruction fetch, LAT=2: after reset, imemREN=1, imemaddr=0x40, ramload=0xDEADBEEF.
  - ramREN=1 with ramaddr=0x40 in cycles 1-2, ihit=1 in cycle 3 only, imemload=0xDEADBEEF from cycle 3.
- Data write: dmemWEN=1, dmemaddr=0x80, dmemstore=0x12345678.
  - ramWEN=1 and ramstore=0x12345678 for 2 cycles, then one dhit. dmemload keeps its prior value.
- Arbitration: imemREN=1 and dmemREN=1 together, addresses 0x0 / 0x100.
  - dhit first (cycle 3), ihit at cycle 7. ramaddr sequence 0x100 then 0x0. Never ihit and dhit together.
- Abort and reset:
  - dmemREN dropped in cycle 1 of ACCESS: no dhit, IDLE in cycle 2.
  - nRST=0 mid-ACCESS: all outputs 0 after the next edge, no hit.
- Sweep LAT=1 and LAT=15 with random request streams, checked against a scoreboard. Require:
  - hit exactly LAT+1 cycles after grant.
  - one hit per completed grant.
  - RAM enables never high outside ACCESS.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// rtl/mem_responder_pkg.sv - shared types for the memory responder
package mem_responder_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} memstate_t;
  typedef enum logic [1:0] {NONE, INSTR, DATA} memgrant_t;
  typedef enum logic {READ, WRITE} memop_t;

  // Wait-state counter width; LAT is limited to 1..15 so 4 bits suffice.
  localparam int CNT_W = 4;
  typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/mem_responder_if.sv
// rtl/mem_responder_if.sv - request-unit and RAM signals of the memory responder
interface mem_responder_if;
  import mem_responder_pkg::*;

  // Request unit side
  logic  imemREN;
  word_t imemaddr;
  logic  dmemREN;
  logic  dmemWEN;
  word_t dmemaddr;
  word_t dmemstore;
  logic  ihit;
  logic  dhit;
  word_t imemload;
  word_t dmemload;

  // RAM side
  logic  ramREN;
  logic  ramWEN;
  word_t ramaddr;
  word_t ramstore;
  word_t ramload;

  // Request unit plus RAM model
  modport master (
    output imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore, ramload,
    input  ihit, dhit, imemload, dmemload, ramREN, ramWEN, ramaddr, ramstore
  );

  // The responder itself
  modport slave (
    input  imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore, ramload,
    output ihit, dhit, imemload, dmemload, ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/mem_responder_wait_counter.sv
// rtl/mem_responder_wait_counter.sv - loadable wait-state down-counter with zero flag
module mem_responder_wait_counter
  import mem_responder_pkg::*;
(
  input  logic CLK,
  input  logic nRST,
  input  logic load,
  input  cnt_t load_val,
  input  logic dec,
  output logic zero
);

  cnt_t count;

  // Load takes priority; decrement saturates at zero.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - single-port RAM arbiter returning ihit/dhit with fixed wait states
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int LAT = 2
)(
  input logic           CLK,
  input logic           nRST,
  mem_responder_if.slave bus
);

  localparam cnt_t LAT_INIT = cnt_t'(LAT - 1);

  memstate_t state;
  memgrant_t grant;
  memop_t    op;
  word_t     addr_q;
  word_t     store_q;
  word_t     imemload_q;
  word_t     dmemload_q;
  logic      ihit_q;
  logic      dhit_q;
  logic      ramren_q;
  logic      ramwen_q;

  logic      dreq;
  logic      ireq;
  logic      req_live;
  logic      cnt_load;
  logic      cnt_dec;
  logic      cnt_zero;

  assign dreq = bus.dmemREN | bus.dmemWEN;
  assign ireq = bus.imemREN;

  // The granted requester must keep its enable up for the access to complete.
  assign req_live = (grant == INSTR) ? ireq : dreq;

  assign cnt_load = (state == IDLE) && (dreq || ireq);
  assign cnt_dec  = (state == ACCESS);

  mem_responder_wait_counter u_wait (
    .CLK      (CLK),
    .nRST     (nRST),
    .load     (cnt_load),
    .load_val (LAT_INIT),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

  // Arbitration FSM; every bus output is a register updated here.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state      <= IDLE;
      grant      <= NONE;
      op         <= READ;
      addr_q     <= '0;
      store_q    <= '0;
      imemload_q <= '0;
      dmemload_q <= '0;
      ihit_q     <= 1'b0;
      dhit_q     <= 1'b0;
      ramren_q   <= 1'b0;
      ramwen_q   <= 1'b0;
    end else begin
      ihit_q <= 1'b0;
      dhit_q <= 1'b0;
      case (state)
        IDLE: begin
          if (dreq) begin
            grant    <= DATA;
            addr_q   <= bus.dmemaddr;
            store_q  <= bus.dmemstore;
            op       <= bus.dmemWEN ? WRITE : READ;
            ramren_q <= ~bus.dmemWEN;
            ramwen_q <= bus.dmemWEN;
            state    <= ACCESS;
          end else if (ireq) begin
            grant    <= INSTR;
            addr_q   <= bus.imemaddr;
            op       <= READ;
            ramren_q <= 1'b1;
            ramwen_q <= 1'b0;
            state    <= ACCESS;
          end
        end
        ACCESS: begin
          if (!req_live) begin
            grant    <= NONE;
            ramren_q <= 1'b0;
            ramwen_q <= 1'b0;
            state    <= IDLE;
          end else if (cnt_zero) begin
            if (grant == INSTR) begin
              imemload_q <= bus.ramload;
            end else if (op == READ) begin
              dmemload_q <= bus.ramload;
            end
            ihit_q   <= (grant == INSTR);
            dhit_q   <= (grant == DATA);
            ramren_q <= 1'b0;
            ramwen_q <= 1'b0;
            state    <= DONE;
          end
        end
        DONE: begin
          grant <= NONE;
          state <= IDLE;
        end
        default: begin
          grant    <= NONE;
          ramren_q <= 1'b0;
          ramwen_q <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  assign bus.ihit     = ihit_q;
  assign bus.dhit     = dhit_q;
  assign bus.imemload = imemload_q;
  assign bus.dmemload = dmemload_q;
  assign bus.ramREN   = ramren_q;
  assign bus.ramWEN   = ramwen_q;
  assign bus.ramaddr  = addr_q;
  assign bus.ramstore = store_q;

endmodule
